// File: rtl/viterbi_codec_k3.sv
// viterbi_codec_k3
// Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal)
// and a matching hard-decision Viterbi decoder using register exchange.
// The encoder and decoder halves share only clock and reset; the channel
// (and any error injection) sits between enc_d_out and dec_d_in.
module viterbi_codec_k3 #(
  parameter int TB_DEPTH = 16,  // survivor length, also decoder latency
  parameter int METRIC_W = 8,   // unsigned path-metric width
  parameter int INIT_BAD = 16   // reset metric of the non-zero states
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out,
  output logic       dec_valid_o
);

  localparam int NSTATES = 4;
  // Candidates carry two extra bits so PM + BM can never wrap before
  // normalization and saturation are applied.
  localparam int CAND_W = METRIC_W + 2;
  localparam int CNT_W  = $clog2(TB_DEPTH + 1);

  localparam logic [CAND_W-1:0]   PM_SAT   = {2'b00, {METRIC_W{1'b1}}};
  localparam logic [METRIC_W-1:0] PM_SAT_M = {METRIC_W{1'b1}};
  localparam logic [METRIC_W-1:0] PM_BAD   = METRIC_W'(INIT_BAD);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(TB_DEPTH);

  // --------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------
  // sr_reg[1] is the previous information bit, sr_reg[0] the one before.
  logic [1:0] sr_reg;
  logic [1:0] enc_sym_reg;
  logic       enc_valid_reg;
  logic [1:0] enc_sym_next;

  // Generator taps: g0 = 1+D+D^2 (7), g1 = 1+D^2 (5).
  always_comb begin
    enc_sym_next = {enc_d_in ^ sr_reg[1] ^ sr_reg[0], enc_d_in ^ sr_reg[0]};
  end

  // Accept a bit when enabled; otherwise hold state and drop valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg        <= 2'b00;
      enc_sym_reg   <= 2'b00;
      enc_valid_reg <= 1'b0;
    end else if (enc_enable_i) begin
      sr_reg        <= {enc_d_in, sr_reg[1]};
      enc_sym_reg   <= enc_sym_next;
      enc_valid_reg <= 1'b1;
    end else begin
      enc_valid_reg <= 1'b0;
    end
  end

  assign enc_d_out   = enc_sym_reg;
  assign enc_valid_o = enc_valid_reg;

  // --------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------
  // Trellis state s = {s1, s0} mirrors the encoder shift register, so an
  // input bit b moves state {s1, s0} to {b, s1}.
  logic [METRIC_W-1:0] pm_reg    [NSTATES];
  logic [METRIC_W-1:0] pm_next   [NSTATES];
  logic [TB_DEPTH-1:0] surv_reg  [NSTATES];
  logic [TB_DEPTH-1:0] surv_next [NSTATES];
  logic [CAND_W-1:0]   cand      [NSTATES];
  logic [CAND_W-1:0]   norm      [NSTATES];
  logic [CAND_W-1:0]   cand_min;
  logic [CNT_W-1:0]    cnt_reg;
  logic                dec_bit_reg;
  logic                dec_valid_reg;
  logic [METRIC_W-1:0] best_pm;
  logic [1:0]          best_idx;
  logic                best_bit;

  // Hamming distance between an expected and a received 2-bit symbol.
  function automatic logic [1:0] branch_metric(input logic [1:0] expected,
                                               input logic [1:0] received);
    logic [1:0] diff;
    diff = expected ^ received;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // One add-compare-select unit per next state ns = {b, x}. Its two
  // predecessors are {x,0} and {x,1}; the expected symbols on those
  // branches are fixed per state and folded into constants.
  genvar gi;
  generate
    for (gi = 0; gi < NSTATES; gi++) begin : g_acs
      localparam logic       B    = 1'(gi >> 1);
      localparam logic       X    = 1'(gi & 1);
      localparam int         P0   = 2 * (gi & 1);
      localparam int         P1   = P0 + 1;
      localparam logic [1:0] EXP0 = {B ^ X, B};
      localparam logic [1:0] EXP1 = {~(B ^ X), ~B};

      logic [1:0]          bm0;
      logic [1:0]          bm1;
      logic [CAND_W-1:0]   cand0;
      logic [CAND_W-1:0]   cand1;
      logic                take1;
      logic [TB_DEPTH-1:0] win_surv;

      assign bm0   = branch_metric(EXP0, dec_d_in);
      assign bm1   = branch_metric(EXP1, dec_d_in);
      assign cand0 = CAND_W'(pm_reg[P0]) + CAND_W'(bm0);
      assign cand1 = CAND_W'(pm_reg[P1]) + CAND_W'(bm1);

      // Strict compare: a tie keeps the {x,0} predecessor.
      assign take1    = (cand1 < cand0);
      assign cand[gi] = take1 ? cand1 : cand0;
      assign win_surv = take1 ? surv_reg[P1] : surv_reg[P0];

      // Register exchange: inherit the winner's history, append b as LSB.
      assign surv_next[gi] = {win_surv[TB_DEPTH-2:0], B};

      // Normalize against the smallest new candidate, then clamp.
      assign norm[gi]    = cand[gi] - cand_min;
      assign pm_next[gi] = (norm[gi] > PM_SAT) ? PM_SAT_M : norm[gi][METRIC_W-1:0];
    end
  endgenerate

  // Minimum of the four new candidates, used to keep metrics small.
  always_comb begin
    cand_min = cand[0];
    for (int i = 1; i < NSTATES; i++) begin
      if (cand[i] < cand_min) begin
        cand_min = cand[i];
      end
    end
  end

  // Best current state (lowest index on ties) supplies the output bit.
  always_comb begin
    best_pm  = pm_reg[0];
    best_idx = 2'd0;
    for (int i = 1; i < NSTATES; i++) begin
      if (pm_reg[i] < best_pm) begin
        best_pm  = pm_reg[i];
        best_idx = 2'(i);
      end
    end
  end

  assign best_bit = surv_reg[best_idx][TB_DEPTH-1];

  // Advance the trellis one symbol per enabled edge; idle edges hold all
  // decoder state so gaps in the symbol stream are transparent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_reg[0]   <= '0;
      surv_reg[0] <= '0;
      for (int i = 1; i < NSTATES; i++) begin
        pm_reg[i]   <= PM_BAD;
        surv_reg[i] <= '0;
      end
      cnt_reg       <= '0;
      dec_bit_reg   <= 1'b0;
      dec_valid_reg <= 1'b0;
    end else if (dec_enable) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_reg[i]   <= pm_next[i];
        surv_reg[i] <= surv_next[i];
      end
      dec_bit_reg   <= best_bit;
      dec_valid_reg <= (cnt_reg == CNT_FULL);
      if (cnt_reg != CNT_FULL) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      dec_valid_reg <= 1'b0;
    end
  end

  assign dec_d_out   = dec_bit_reg;
  assign dec_valid_o = dec_valid_reg;

endmodule

// File: tb/tb_viterbi_codec_k3.sv
// Testbench for viterbi_codec_k3: encoder vectors, encoder hold, clean
// encoder->decoder loop, enable gaps, sparse and burst channel errors, and
// asynchronous reset in the middle of a stream.
`timescale 1ns/1ps
module tb_viterbi_codec_k3;

  localparam int TB_DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_in;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable;
  logic [1:0] dec_d_in;
  logic       dec_d_out;
  logic       dec_valid_o;

  always #5 clk = ~clk;

  viterbi_codec_k3 #(
    .TB_DEPTH(TB_DEPTH),
    .METRIC_W(8),
    .INIT_BAD(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_enable_i(enc_enable_i),
    .enc_d_in    (enc_d_in),
    .enc_valid_o (enc_valid_o),
    .enc_d_out   (enc_d_out),
    .dec_enable  (dec_enable),
    .dec_d_in    (dec_d_in),
    .dec_d_out   (dec_d_out),
    .dec_valid_o (dec_valid_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain history of information bits.
  bit         hist[$];     // bits accepted by the encoder since reset
  bit         sent[$];     // bits whose symbols have reached the decoder
  int         dec_edges;   // enabled decoder edges since reset
  bit         last_enc_bit;
  logic       fed;
  logic       exp_ev;
  logic [1:0] exp_es;
  logic       exp_dv;
  logic       exp_db;

  // Coded symbol for bit d given the two most recent earlier bits.
  function automatic logic [1:0] enc_expect(input bit d);
    bit p1;
    bit p2;
    p1 = (hist.size() >= 1) ? hist[hist.size()-1] : 1'b0;
    p2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    return {d ^ p1 ^ p2, d ^ p2};
  endfunction

  task automatic clear_model();
    hist.delete();
    sent.delete();
    dec_edges    = 0;
    last_enc_bit = 1'b0;
    exp_ev       = 1'b0;
    exp_es       = 2'b00;
    exp_dv       = 1'b0;
    exp_db       = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    dec_enable   = 1'b0;
    dec_d_in     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
  endtask

  // One clock: encoder gets (en, d); decoder gets the encoder's current
  // symbol XOR err whenever that symbol is fresh. Updates expectations.
  task automatic drive_cycle(input bit en, input bit d, input logic [1:0] err);
    fed          = enc_valid_o;
    enc_enable_i = en;
    enc_d_in     = d;
    dec_enable   = enc_valid_o;
    dec_d_in     = enc_d_out ^ err;
    @(posedge clk);
    #1;
    if (fed) begin
      sent.push_back(last_enc_bit);
      dec_edges++;
      exp_dv = (dec_edges > TB_DEPTH);
      exp_db = exp_dv ? sent[dec_edges - TB_DEPTH - 1] : 1'b0;
    end else begin
      exp_dv = 1'b0;
      exp_db = 1'b0;
    end
    if (en) begin
      exp_es = enc_expect(d);
      hist.push_back(d);
      last_enc_bit = d;
      exp_ev = 1'b1;
    end else begin
      exp_ev = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (enc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_enc_valid got=%b want=0", enc_valid_o);
    end
    checks++;
    if (enc_d_out !== 2'b00) begin
      failures++;
      $display("FAIL reset_enc_d_out got=%b want=00", enc_d_out);
    end
    checks++;
    if (dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_dec_valid got=%b want=0", dec_valid_o);
    end
    checks++;
    if (dec_d_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_dec_d_out got=%b want=0", dec_d_out);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_enc_vector();
    bit         vin[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] vout[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, vin[i], 2'b00);
      checks++;
      if (enc_valid_o !== 1'b1 || enc_d_out !== vout[i]) begin
        failures++;
        $display("FAIL enc_vector i=%0d got v=%b sym=%b want v=1 sym=%b",
                 i, enc_valid_o, enc_d_out, vout[i]);
      end
    end
    $display("test_enc_vector done checks=%0d failures=%0d", checks, failures);
  endtask

  // Continues the stream left by test_enc_vector.
  task automatic test_enc_hold();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), 2'b00);
      checks++;
      if (enc_valid_o !== 1'b0 || enc_d_out !== exp_es) begin
        failures++;
        $display("FAIL enc_hold gap=%0d got v=%b sym=%b want v=0 sym=%b",
                 i, enc_valid_o, enc_d_out, exp_es);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00);
      checks++;
      if (enc_valid_o !== 1'b1 || enc_d_out !== exp_es) begin
        failures++;
        $display("FAIL enc_resume i=%0d got v=%b sym=%b want v=1 sym=%b",
                 i, enc_valid_o, enc_d_out, exp_es);
      end
    end
    $display("test_enc_hold done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clean_loop();
    int first_valid = 0;
    do_reset();
    for (int c = 0; c < 276; c++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00);
      if (dec_valid_o === 1'b1 && first_valid == 0) first_valid = dec_edges;
      checks++;
      if (enc_valid_o !== exp_ev || enc_d_out !== exp_es) begin
        failures++;
        $display("FAIL clean_enc cyc=%0d got v=%b sym=%b want v=%b sym=%b",
                 c, enc_valid_o, enc_d_out, exp_ev, exp_es);
      end
      checks++;
      if (dec_valid_o !== exp_dv) begin
        failures++;
        $display("FAIL clean_dec_valid edge=%0d got=%b want=%b", dec_edges, dec_valid_o, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (dec_d_out !== exp_db) begin
          failures++;
          $display("FAIL clean_dec_bit edge=%0d got=%b want=%b", dec_edges, dec_d_out, exp_db);
        end
      end
    end
    checks++;
    if (first_valid != TB_DEPTH + 1) begin
      failures++;
      $display("FAIL clean_first_valid got edge=%0d want edge=%0d", first_valid, TB_DEPTH + 1);
    end
    $display("test_clean_loop done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_gaps();
    do_reset();
    for (int c = 0; c < 240; c++) begin
      drive_cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 2'b00);
      checks++;
      if (enc_valid_o !== exp_ev || enc_d_out !== exp_es) begin
        failures++;
        $display("FAIL gaps_enc cyc=%0d got v=%b sym=%b want v=%b sym=%b",
                 c, enc_valid_o, enc_d_out, exp_ev, exp_es);
      end
      checks++;
      if (dec_valid_o !== exp_dv) begin
        failures++;
        $display("FAIL gaps_dec_valid cyc=%0d got=%b want=%b", c, dec_valid_o, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (dec_d_out !== exp_db) begin
          failures++;
          $display("FAIL gaps_dec_bit edge=%0d got=%b want=%b", dec_edges, dec_d_out, exp_db);
        end
      end
    end
    $display("test_gaps done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_injected_errors();
    logic [1:0] err;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      err = ((dec_edges % 20) == 10 && dec_edges < 260) ? 2'b11 : 2'b00;
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), err);
      checks++;
      if (dec_valid_o !== exp_dv) begin
        failures++;
        $display("FAIL inj_dec_valid edge=%0d got=%b want=%b", dec_edges, dec_valid_o, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (dec_d_out !== exp_db) begin
          failures++;
          $display("FAIL inj_dec_bit edge=%0d got=%b want=%b", dec_edges, dec_d_out, exp_db);
        end
      end
    end
    $display("test_injected_errors done checks=%0d failures=%0d", checks, failures);
  endtask

  // Burst on decoder symbols 100..103; output must be exact before the
  // burst reaches the decoder and again from TB_DEPTH+4 symbols after it.
  task automatic test_burst();
    logic [1:0] err;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      err = (dec_edges >= 100 && dec_edges <= 103) ? 2'b11 : 2'b00;
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), err);
      checks++;
      if (dec_valid_o !== exp_dv) begin
        failures++;
        $display("FAIL burst_dec_valid edge=%0d got=%b want=%b", dec_edges, dec_valid_o, exp_dv);
      end
      if (exp_dv && ((dec_edges - 1) < 100 || (dec_edges - 1) >= 104 + TB_DEPTH + 4)) begin
        checks++;
        if (dec_d_out !== exp_db) begin
          failures++;
          $display("FAIL burst_dec_bit edge=%0d got=%b want=%b", dec_edges, dec_d_out, exp_db);
        end
      end
    end
    $display("test_burst done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_midstream();
    int first_valid = 0;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00);
      checks++;
      if (enc_valid_o !== exp_ev || enc_d_out !== exp_es) begin
        failures++;
        $display("FAIL mid_enc cyc=%0d got v=%b sym=%b want v=%b sym=%b",
                 c, enc_valid_o, enc_d_out, exp_ev, exp_es);
      end
    end
    // Asynchronous assertion, checked before any clock edge arrives.
    enc_enable_i = 1'b0;
    dec_enable   = 1'b0;
    rst          = 1'b0;
    #1;
    checks++;
    if ({enc_valid_o, enc_d_out, dec_valid_o, dec_d_out} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got ev=%b es=%b dv=%b db=%b want all 0",
               enc_valid_o, enc_d_out, dec_valid_o, dec_d_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    for (int c = 0; c < 90; c++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 2'b00);
      if (dec_valid_o === 1'b1 && first_valid == 0) first_valid = dec_edges;
      checks++;
      if (dec_valid_o !== exp_dv) begin
        failures++;
        $display("FAIL mid_dec_valid edge=%0d got=%b want=%b", dec_edges, dec_valid_o, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (dec_d_out !== exp_db) begin
          failures++;
          $display("FAIL mid_dec_bit edge=%0d got=%b want=%b", dec_edges, dec_d_out, exp_db);
        end
      end
    end
    checks++;
    if (first_valid != TB_DEPTH + 1) begin
      failures++;
      $display("FAIL mid_first_valid got edge=%0d want edge=%0d", first_valid, TB_DEPTH + 1);
    end
    $display("test_reset_midstream done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_in     = 1'b0;
    dec_enable   = 1'b0;
    dec_d_in     = 2'b00;
    clear_model();
    test_reset();
    test_enc_vector();
    test_enc_hold();
    test_clean_loop();
    test_gaps();
    test_injected_errors();
    test_burst();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
